// File: rtl/mcu_channel_buffer_if.sv
// Write/read port bundle for the MCU channel buffer: block writes in, aligned YCbCr triples out.
// The buffer takes the slave view and the source/consumer side takes the master view.
interface mcu_channel_buffer_if #(
    parameter int unsigned Q     = 16,
    parameter int unsigned MAX_Y = 4
);
    logic [MAX_Y-1:0][7:0][7:0][Q-1:0] blocks_in;
    logic                              wr_en;
    logic [1:0]                        ch;
    logic [1:0]                        mode;
    logic                              in_ready;
    logic [7:0][7:0][Q-1:0]            y_out;
    logic [7:0][7:0][Q-1:0]            cb_out;
    logic [7:0][7:0][Q-1:0]            cr_out;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_last;
    logic                              err;

    modport master (
        output blocks_in, wr_en, ch, mode, out_ready,
        input  in_ready, y_out, cb_out, cr_out, out_valid, out_last, err
    );

    modport slave (
        input  blocks_in, wr_en, ch, mode, out_ready,
        output in_ready, y_out, cb_out, cr_out, out_valid, out_last, err
    );
endinterface

// File: rtl/mcu_channel_buffer.sv
// Ping-pong MCU buffer: fills Y, Cb, Cr blocks of one MCU per bank and replays them as
// (Y,Cb,Cr) triples with valid/ready, while the next bank fills independently.
module mcu_channel_buffer #(
    parameter int unsigned Q     = 16,
    parameter int unsigned MAX_Y = 4,
    parameter int unsigned NBANK = 2
) (
    input logic                 clk,
    input logic                 rst,
    mcu_channel_buffer_if.slave bus
);
    localparam int unsigned CW = $clog2(MAX_Y + 1);
    localparam int unsigned IW = (MAX_Y > 1) ? $clog2(MAX_Y) : 1;
    localparam int unsigned PW = $clog2(NBANK);

    localparam logic [2:0] StEmpty  = 3'd0;
    localparam logic [2:0] StFillY  = 3'd1;
    localparam logic [2:0] StFillCb = 3'd2;
    localparam logic [2:0] StFillCr = 3'd3;
    localparam logic [2:0] StFull   = 3'd4;
    localparam logic [2:0] StDrain  = 3'd5;

    typedef logic [MAX_Y-1:0][7:0][7:0][Q-1:0] mcu_t;

    logic [2:0]    state_q [NBANK];
    logic [2:0]    state_d [NBANK];
    logic [CW-1:0] n_q     [NBANK];
    logic [CW-1:0] n_d     [NBANK];
    logic [CW-1:0] ycnt_q  [NBANK];
    logic [CW-1:0] ycnt_d  [NBANK];
    logic [PW-1:0] wr_bank_q, wr_bank_d;
    logic [PW-1:0] rd_bank_q, rd_bank_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic          err_q, err_d;
    mcu_t          y_q  [NBANK];
    mcu_t          cb_q [NBANK];
    mcu_t          cr_q [NBANK];

    logic [2:0]    wr_st, rd_st;
    logic          in_ready, out_valid;
    logic [CW-1:0] n_new, n_wr, y_idx;
    logic          y_we, cb_we, cr_we;

    assign wr_st     = state_q[wr_bank_q];
    assign rd_st     = state_q[rd_bank_q];
    assign in_ready  = (wr_st == StEmpty) || (wr_st == StFillY) ||
                       (wr_st == StFillCb) || (wr_st == StFillCr);
    assign out_valid = (rd_st == StDrain);

    // Reserved mode falls back to the largest layout so the MCU can still complete.
    always_comb begin
        case (bus.mode)
            2'd0:    n_new = CW'(1);
            2'd1:    n_new = CW'(2);
            default: n_new = CW'(4);
        endcase
    end

    assign n_wr  = (wr_st == StEmpty) ? n_new : n_q[wr_bank_q];
    assign y_idx = (wr_st == StEmpty) ? '0 : ycnt_q[wr_bank_q];

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        ycnt_d    = ycnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        err_d     = err_q;
        y_we      = 1'b0;
        cb_we     = 1'b0;
        cr_we     = 1'b0;

        if (bus.wr_en && in_ready) begin
            if (bus.ch == 2'd0 && (wr_st == StEmpty || wr_st == StFillY)) begin
                y_we               = 1'b1;
                n_d[wr_bank_q]     = n_wr;
                ycnt_d[wr_bank_q]  = y_idx + CW'(1);
                state_d[wr_bank_q] = (y_idx + CW'(1) == n_wr) ? StFillCb : StFillY;
                if (wr_st == StEmpty && bus.mode == 2'd3) begin
                    err_d = 1'b1;
                end
            end else if (bus.ch == 2'd1 && wr_st == StFillCb) begin
                cb_we              = 1'b1;
                state_d[wr_bank_q] = StFillCr;
            end else if (bus.ch == 2'd2 && wr_st == StFillCr) begin
                cr_we              = 1'b1;
                state_d[wr_bank_q] = StFull;
                wr_bank_d          = wr_bank_q + PW'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        // Read side only touches FULL/DRAIN banks, so it never collides with the fill above.
        if (rd_st == StFull) begin
            state_d[rd_bank_q] = StDrain;
            rd_idx_d           = '0;
        end else if (out_valid && bus.out_ready) begin
            if (rd_idx_q == n_q[rd_bank_q] - CW'(1)) begin
                state_d[rd_bank_q] = StEmpty;
                rd_bank_d          = rd_bank_q + PW'(1);
                rd_idx_d           = '0;
            end else begin
                rd_idx_d = rd_idx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                state_q[b] <= StEmpty;
                n_q[b]     <= '0;
                ycnt_q[b]  <= '0;
            end
            wr_bank_q <= '0;
            rd_bank_q <= '0;
            rd_idx_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            ycnt_q    <= ycnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                y_q[b]  <= '0;
                cb_q[b] <= '0;
                cr_q[b] <= '0;
            end
        end else begin
            if (y_we) begin
                y_q[wr_bank_q][IW'(y_idx)] <= bus.blocks_in[0];
            end
            for (int i = 0; i < MAX_Y; i++) begin
                if (cb_we && CW'(i) < n_q[wr_bank_q]) begin
                    cb_q[wr_bank_q][i] <= bus.blocks_in[i];
                end
                if (cr_we && CW'(i) < n_q[wr_bank_q]) begin
                    cr_q[wr_bank_q][i] <= bus.blocks_in[i];
                end
            end
        end
    end

    always_comb begin
        bus.y_out    = '0;
        bus.cb_out   = '0;
        bus.cr_out   = '0;
        bus.out_last = 1'b0;
        if (out_valid) begin
            bus.y_out    = y_q[rd_bank_q][IW'(rd_idx_q)];
            bus.cb_out   = cb_q[rd_bank_q][IW'(rd_idx_q)];
            bus.cr_out   = cr_q[rd_bank_q][IW'(rd_idx_q)];
            bus.out_last = (rd_idx_q == n_q[rd_bank_q] - CW'(1));
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mcu_channel_buffer.sv
// Scoreboard bench for mcu_channel_buffer: expected triples are queued as each MCU is written
// and popped as the DUT presents them; inputs change and outputs are sampled on the negedge.
module tb_mcu_channel_buffer;
    typedef logic [7:0][7:0][15:0]      blk_t;
    typedef logic [3:0][7:0][7:0][15:0] mcu_t;
    typedef struct {
        blk_t y;
        blk_t cb;
        blk_t cr;
        logic last;
    } trip_t;

    logic  clk;
    logic  rst;
    int    total = 0;
    int    bad   = 0;
    trip_t sb[$];

    mcu_channel_buffer_if #(.Q(16), .MAX_Y(4)) bus ();

    mcu_channel_buffer #(.Q(16), .MAX_Y(4), .NBANK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic blk_t mk(input logic [15:0] base);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = base + 16'((r * 8 + c) << 8);
        return b;
    endfunction

    function automatic mcu_t mk4(input logic [15:0] base);
        mcu_t m;
        for (int i = 0; i < 4; i++) m[i] = mk(base + 16'(i));
        return m;
    endfunction

    task automatic wr(input logic [1:0] c, input logic [1:0] m, input mcu_t d);
        bus.ch        = c;
        bus.mode      = m;
        bus.blocks_in = d;
        bus.wr_en     = 1'b1;
        @(negedge clk);
        bus.wr_en     = 1'b0;
    endtask

    task automatic wr_mcu(input logic [1:0] m, input int n, input logic [15:0] yb,
                          input logic [15:0] cbb, input logic [15:0] crb);
        mcu_t  ym, cbm, crm;
        trip_t t;
        for (int k = 0; k < n; k++) begin
            ym    = '0;
            ym[0] = mk(yb + 16'(k));
            wr(2'd0, m, ym);
        end
        cbm = mk4(cbb);
        crm = mk4(crb);
        wr(2'd1, m, cbm);
        wr(2'd2, m, crm);
        for (int k = 0; k < n; k++) begin
            t.y    = mk(yb + 16'(k));
            t.cb   = cbm[k];
            t.cr   = crm[k];
            t.last = (k == n - 1);
            sb.push_back(t);
        end
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.ch        = 2'd0;
        bus.mode      = 2'd0;
        bus.blocks_in = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b/%b exp=0/0", bus.out_valid, bus.out_last);
        end
        total++;
        if (bus.err !== 1'b0) begin
            bad++; $display("FAIL reset_err got=%b exp=0", bus.err);
        end
        total++;
        if (bus.y_out !== '0 || bus.cb_out !== '0 || bus.cr_out !== '0) begin
            bad++; $display("FAIL reset_data y00=%h exp=0", bus.y_out[0][0]);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_420;
        bus.out_ready = 1'b1;
        wr_mcu(2'd2, 4, 16'h10, 16'hA0, 16'hC0);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL t1_latency valid got=%b exp=0", bus.out_valid);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (sb.size() == 0 || bus.out_valid !== 1'b1 || bus.y_out !== sb[0].y ||
                bus.cb_out !== sb[0].cb || bus.cr_out !== sb[0].cr || bus.out_last !== sb[0].last) begin
                bad++;
                $display("FAIL t1_triple k=%0d valid=%b y00=%h exp=%h last=%b exp=%b", k,
                         bus.out_valid, bus.y_out[0][0], 16'h10 + 16'(k), bus.out_last, k == 3);
            end
            if (sb.size() > 0) void'(sb.pop_front());
            @(negedge clk);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL t1_after valid got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        mcu_t ym;
        bus.out_ready = 1'b0;
        wr_mcu(2'd0, 1, 16'h20, 16'h30, 16'h40);
        wr_mcu(2'd0, 1, 16'h21, 16'h31, 16'h41);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL t2_full in_ready got=%b exp=0", bus.in_ready);
        end
        ym    = '0;
        ym[0] = mk(16'h77);
        wr(2'd0, 2'd0, ym);
        total++;
        if (bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL t2_ignored err=%b in_ready=%b exp=0/0", bus.err, bus.in_ready);
        end
        total++;
        if (sb.size() == 0 || bus.out_valid !== 1'b1 || bus.y_out !== sb[0].y) begin
            bad++; $display("FAIL t2_stalled valid=%b y00=%h exp=0020", bus.out_valid, bus.y_out[0][0]);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() != 0; c++) begin
            if (bus.out_valid) begin
                total++;
                if (bus.y_out !== sb[0].y || bus.cb_out !== sb[0].cb || bus.cr_out !== sb[0].cr ||
                    bus.out_last !== sb[0].last) begin
                    bad++;
                    $display("FAIL t2_triple y00=%h exp=%h last=%b exp=%b", bus.y_out[0][0],
                             sb[0].y[0][0], bus.out_last, sb[0].last);
                end
                void'(sb.pop_front());
            end
            @(negedge clk);
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL t2_timeout left=%0d exp=0", sb.size());
            sb.delete();
        end
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL t2_end in_ready=%b valid=%b exp=1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] pat;
        int         hs;
        pat           = 4'b1001;
        hs            = 0;
        bus.out_ready = 1'b0;
        wr_mcu(2'd1, 2, 16'h50, 16'h60, 16'h70);
        for (int c = 0; c < 5 && !bus.out_valid; c++) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.out_ready = pat[k];
            total++;
            if (sb.size() == 0 || bus.out_valid !== 1'b1 || bus.y_out !== sb[0].y ||
                bus.cb_out !== sb[0].cb || bus.cr_out !== sb[0].cr || bus.out_last !== sb[0].last) begin
                bad++;
                $display("FAIL t3_hold k=%0d valid=%b y00=%h last=%b", k, bus.out_valid,
                         bus.y_out[0][0], bus.out_last);
            end
            if (bus.out_valid && pat[k]) begin
                hs++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        total++;
        if (hs != 2) begin
            bad++; $display("FAIL t3_handshakes got=%0d exp=2", hs);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL t3_after valid got=%b exp=0", bus.out_valid);
        end
        sb.delete();
    endtask

    task automatic test_mode_latch;
        mcu_t  ym, cbm, crm;
        trip_t t;
        bus.out_ready = 1'b1;
        cbm           = mk4(16'hD0);
        crm           = mk4(16'hF0);
        for (int k = 0; k < 2; k++) begin
            ym    = '0;
            ym[0] = mk(16'h58 + 16'(k));
            wr(2'd0, (k == 0) ? 2'd1 : 2'd2, ym);
        end
        wr(2'd1, 2'd2, cbm);
        wr(2'd2, 2'd2, crm);
        for (int k = 0; k < 2; k++) begin
            t.y    = mk(16'h58 + 16'(k));
            t.cb   = cbm[k];
            t.cr   = crm[k];
            t.last = (k == 1);
            sb.push_back(t);
        end
        for (int c = 0; c < 8 && sb.size() != 0; c++) begin
            if (bus.out_valid) begin
                total++;
                if (bus.y_out !== sb[0].y || bus.cb_out !== sb[0].cb || bus.cr_out !== sb[0].cr ||
                    bus.out_last !== sb[0].last) begin
                    bad++;
                    $display("FAIL t5_triple y00=%h exp=%h last=%b exp=%b", bus.y_out[0][0],
                             sb[0].y[0][0], bus.out_last, sb[0].last);
                end
                void'(sb.pop_front());
            end
            @(negedge clk);
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL t5_timeout left=%0d exp=0", sb.size());
            sb.delete();
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin
            bad++; $display("FAIL t5_end valid=%b err=%b exp=0/0", bus.out_valid, bus.err);
        end
    endtask

    task automatic test_protocol;
        wr(2'd1, 2'd0, mk4(16'hE0));
        total++;
        if (bus.err !== 1'b1) begin
            bad++; $display("FAIL t4_err got=%b exp=1", bus.err);
        end
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL t4_dropped in_ready=%b valid=%b exp=1/0", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        wr_mcu(2'd0, 1, 16'h80, 16'h90, 16'hB0);
        for (int c = 0; c < 8 && sb.size() != 0; c++) begin
            if (bus.out_valid) begin
                total++;
                if (bus.y_out !== sb[0].y || bus.cb_out !== sb[0].cb || bus.cr_out !== sb[0].cr ||
                    bus.out_last !== sb[0].last) begin
                    bad++;
                    $display("FAIL t4_triple y00=%h exp=%h last=%b exp=%b", bus.y_out[0][0],
                             sb[0].y[0][0], bus.out_last, sb[0].last);
                end
                void'(sb.pop_front());
            end
            @(negedge clk);
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL t4_timeout left=%0d exp=0", sb.size());
            sb.delete();
        end
        total++;
        if (bus.err !== 1'b1) begin
            bad++; $display("FAIL t4_sticky err=%b exp=1", bus.err);
        end
    endtask

    task automatic test_async_reset;
        bus.out_ready = 1'b0;
        wr_mcu(2'd2, 4, 16'h30, 16'h40, 16'h50);
        for (int c = 0; c < 5 && !bus.out_valid; c++) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL t6_pre valid got=%b exp=1", bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL t6_ctrl valid=%b last=%b in_ready=%b exp=0/0/1", bus.out_valid,
                     bus.out_last, bus.in_ready);
        end
        total++;
        if (bus.y_out !== '0 || bus.cb_out !== '0 || bus.cr_out !== '0 || bus.err !== 1'b0) begin
            bad++; $display("FAIL t6_data y00=%h err=%b exp=0/0", bus.y_out[0][0], bus.err);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL t6_post valid got=%b exp=0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_420();
        test_back_to_back();
        test_backpressure();
        test_mode_latch();
        test_protocol();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
